mult_div_unit: RTL

//   Multi-cycle multiply/divide unit in the E stage. Owns the HI/LO registers.

---
 rtl/mult_div_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers for the E stage.
// Optional MADD/MADDU accumulate ops are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MADDU = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_r;
   logic             busy_r;
   logic [CNT_W-1:0] count_r;
   logic [31:0]      p_hi_r;
   logic [31:0]      p_lo_r;
   logic [31:0]      hi_r;
   logic [31:0]      lo_r;

   logic [63:0]        smul_s;
   logic [63:0]        umul_s;
   logic               div_zero_s;
   logic               div_ovf_s;
   logic signed [31:0] sdivisor_s;
   logic signed [31:0] squot_s;
   logic signed [31:0] srem_s;
   logic [31:0]        udivisor_s;
   logic [31:0]        uquot_s;
   logic [31:0]        urem_s;

   logic [63:0]      result_s;
   logic [CNT_W-1:0] lat_s;
   logic             arith_s;

   // Datapath: full-width products and guarded quotients for every arithmetic op.
   assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign umul_s = {32'h0000_0000, A} * {32'h0000_0000, B};

   // Divisor forced to 1 on zero/overflow so the dividers never see an undefined case;
   // those results are substituted below.
   assign div_zero_s = (B == 32'h0000_0000);
   assign div_ovf_s  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign sdivisor_s = (div_zero_s || div_ovf_s) ? 32'sd1 : $signed(B);
   assign squot_s    = $signed(A) / sdivisor_s;
   assign srem_s     = $signed(A) % sdivisor_s;
   assign udivisor_s = div_zero_s ? 32'h0000_0001 : B;
   assign uquot_s    = A / udivisor_s;
   assign urem_s     = A % udivisor_s;

   // Select the pending {HI,LO} result and latency for the op being offered.
   always_comb begin
      result_s = 64'h0;
      lat_s    = MULT_CNT;
      arith_s  = 1'b0;
      case (op)
         OP_MULT: begin
            result_s = smul_s;
            lat_s    = MULT_CNT;
            arith_s  = 1'b1;
         end
         OP_MULTU: begin
            result_s = umul_s;
            lat_s    = MULT_CNT;
            arith_s  = 1'b1;
         end
         OP_DIV: begin
            lat_s   = DIV_CNT;
            arith_s = 1'b1;
            if (div_zero_s) begin
               result_s = {A, 32'hFFFF_FFFF};
            end else if (div_ovf_s) begin
               result_s = {32'h0000_0000, 32'h8000_0000};
            end else begin
               result_s = {srem_s, squot_s};
            end
         end
         OP_DIVU: begin
            lat_s   = DIV_CNT;
            arith_s = 1'b1;
            if (div_zero_s) begin
               result_s = {A, 32'hFFFF_FFFF};
            end else begin
               result_s = {urem_s, uquot_s};
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            result_s = {hi_r, lo_r} + smul_s;
            lat_s    = MULT_CNT;
            arith_s  = 1'b1;
         end
         OP_MADDU: begin
            result_s = {hi_r, lo_r} + umul_s;
            lat_s    = MULT_CNT;
            arith_s  = 1'b1;
         end
`else
         OP_MADD, OP_MADDU: begin
            result_s = 64'h0;
            lat_s    = MULT_CNT;
            arith_s  = 1'b0;
         end
`endif
         default: begin
            result_s = 64'h0;
            lat_s    = MULT_CNT;
            arith_s  = 1'b0;
         end
      endcase
   end

   // Control FSM: accept when idle, count down while running, commit on the last busy edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         count_r <= '0;
         p_hi_r  <= 32'h0000_0000;
         p_lo_r  <= 32'h0000_0000;
         hi_r    <= 32'h0000_0000;
         lo_r    <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && arith_s) begin
                  p_hi_r  <= result_s[63:32];
                  p_lo_r  <= result_s[31:0];
                  count_r <= lat_s;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else if (start && (op == OP_MTHI)) begin
                  hi_r <= A;
               end else if (start && (op == OP_MTLO)) begin
                  lo_r <= A;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_RUN: begin
               count_r <= count_r - CNT_ONE;
               if (count_r == CNT_ONE) begin
                  hi_r    <= p_hi_r;
                  lo_r    <= p_lo_r;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  busy_r <= 1'b1;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               count_r <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule
